// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage sitting directly upstream of the decoder. It owns
// the program counter and keeps at most one request in flight to instruction
// memory. It buffers the returned word and presents it to the decoder with a
// state tag: 0 = nope, 1 = keep (same word re-presented), 2 = next (new word).
// Branch redirects may arrive at any time. A response that belongs to a
// redirected-away request is discarded instead of being presented.
//
// Ports:
//   clk                 single clock
//   rst_n               asynchronous, active-low reset
//   imem_req_valid      request valid (only while in REQ)
//   imem_req_ready      memory accepts the request
//   imem_req_addr       request address, always equal to the current pc
//   imem_rsp_valid      one-cycle response strobe per accepted request
//   imem_rsp_data       returned instruction word
//   dec_stall           decoder cannot consume the presented word this cycle
//   branch_valid        one-cycle redirect pulse
//   branch_target       redirect pc
//   fd_state            0 nope, 1 keep, 2 next
//   fd_raw_instruction  buffered instruction word
//   fd_pc               pc of the buffered instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            dec_stall,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  output logic [1:0]      fd_state,
  output logic [ILEN-1:0] fd_raw_instruction,
  output logic [XLEN-1:0] fd_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop_pending, drop_n;
  logic            first, first_n;
  logic [ILEN-1:0] instr_buf, instr_n;
  logic [XLEN-1:0] pc_buf, pc_buf_n;

  // Register bank: FSM state, pc and the presentation buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      drop_pending <= 1'b0;
      first        <= 1'b0;
      instr_buf    <= '0;
      pc_buf       <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      drop_pending <= drop_n;
      first        <= first_n;
      instr_buf    <= instr_n;
      pc_buf       <= pc_buf_n;
    end
  end

  // Next-state logic. A redirect always wins over anything else happening in
  // the same cycle: it discards a simultaneous response and it pre-empts
  // consumption of the buffered word.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    drop_n   = drop_pending;
    first_n  = first;
    instr_n  = instr_buf;
    pc_buf_n = pc_buf;
    unique case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        if (branch_valid) begin
          pc_n = branch_target;
        end
        // The request being accepted was for the old pc; if a redirect
        // lands in the same cycle its response must be thrown away.
        if (imem_req_ready) begin
          state_n = S_WAIT;
          drop_n  = branch_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_n  = 1'b0;
          state_n = S_REQ;
          if (branch_valid) begin
            pc_n = branch_target;
          end else if (!drop_pending) begin
            instr_n  = imem_rsp_data;
            pc_buf_n = pc;
            pc_n     = pc + XLEN'(PC_STEP);
            first_n  = 1'b1;
            state_n  = S_FULL;
          end
        end else if (branch_valid) begin
          pc_n   = branch_target;
          drop_n = 1'b1;
        end
      end
      S_FULL: begin
        first_n = 1'b0;
        if (branch_valid) begin
          pc_n    = branch_target;
          state_n = S_REQ;
        end else if (!dec_stall) begin
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registers.
  assign imem_req_valid     = (state == S_REQ);
  assign imem_req_addr      = pc;
  assign fd_state           = (state == S_FULL) ? (first ? 2'd2 : 2'd1) : 2'd0;
  assign fd_raw_instruction = instr_buf;
  assign fd_pc              = pc_buf;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage; sits directly upstream of the decoder.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Buffers the returned word and presents it to the decoder with a 2-bit state tag (nope/keep/next).
- Handles decoder back-pressure and branch redirects, including dropping stale in-flight responses.

Parameters:
XLEN, 32, PC and instruction-memory address width
ILEN, 32, raw instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  the single clock
rst_n  in  1  reset; asynchronous, active-low
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (current PC)
imem_rsp_valid  in  1  response valid; one cycle per accepted request, any latency >=1
imem_rsp_data  in  ILEN  response instruction word
dec_stall  in  1  decoder cannot consume the presented instruction this cycle
branch_valid  in  1  redirect request (one-cycle pulse)
branch_target  in  XLEN  redirect PC
fd_state  out  2  0=nope (no instruction), 1=keep (same instruction re-presented), 2=next (new instruction), 3 unused
fd_raw_instruction  out  ILEN  buffered instruction
fd_pc  out  XLEN  PC of buffered instruction

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, drop_pending=0, first=0, imem_req_valid=0, imem_req_addr=RESET_PC, fd_state=0, fd_raw_instruction=0, fd_pc=0.
- Reset asserted mid-operation: abandons any outstanding request; its response is ignored, since the FSM is in IDLE/REQ.
- imem_req_addr always equals pc. imem_req_valid=1 only in REQ. All fd_* outputs derive from registers only; no input->output combinational path.

FSM states and transitions:
- IDLE: -> REQ unconditionally on the first clock after reset release.
- REQ:
  - Request handshake = imem_req_valid & imem_req_ready; on handshake -> WAIT.
  - branch_valid without handshake: pc<=branch_target; stay REQ.
  - branch_valid with handshake: pc<=branch_target, drop_pending<=1, -> WAIT.
- WAIT:
  - imem_rsp_valid & !drop_pending & !branch_valid: buffer<=imem_rsp_data, fd_pc<=pc, pc<=pc+PC_STEP, first<=1, -> FULL.
  - imem_rsp_valid & drop_pending: discard data, drop_pending<=0, -> REQ (pc already holds the target).
  - imem_rsp_valid & branch_valid: discard data, pc<=branch_target, drop_pending<=0, -> REQ.
  - branch_valid without response: pc<=branch_target, drop_pending<=1, stay WAIT.
- FULL:
  - fd_state = 2 if first=1, else 1. first<=0 after every FULL cycle.
  - dec_stall=0: instruction consumed this cycle; -> REQ.
  - dec_stall=1: stay FULL; the next cycle shows fd_state=1 with identical data.
  - branch_valid: beats consumption; buffer invalidated, pc<=branch_target, -> REQ.
- Outside FULL, fd_state=0. fd_raw_instruction and fd_pc hold their last value (don't-care).

Arithmetic and protocol rules:
- pc+PC_STEP wraps modulo 2^XLEN; no overflow flag.
- Redirect targets are not alignment-checked.
- At most one request is outstanding; no new request issues until the response is consumed or dropped.
- A response seen in IDLE/REQ/FULL is a protocol error and is ignored.
- Best-case throughput: one instruction per 3 cycles with 1-cycle memory latency.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 0x00A00093 -> imem_req_valid=1, addr=0x0 in cycle 1; cycle 3: fd_state=2, fd_raw_instruction=0x00A00093, fd_pc=0x0; next request addr=0x4.
- dec_stall=1 for 3 cycles while FULL -> fd_state sequence 2,1,1,1, data stable; stall drops -> REQ, addr=0x4.
- branch_valid (target 0x100) in WAIT; stale response 0xDEADBEEF arrives 2 cycles later -> never presented (fd_state stays 0); next request addr=0x100.
- branch_valid same cycle as the REQ handshake -> response dropped; a second request issues to the target.
- branch_valid while FULL with dec_stall=0 -> fd_state=0 the next cycle; request addr=target.
- RESET_PC=0xFFFFFFFC, fetch one instruction -> fd_pc=0xFFFFFFFC; next request addr=0x0 (wrap).
- Assert rst_n=0 while in WAIT -> outputs return to reset values asynchronously.
